// File: rtl/autoconfig_pkg.sv
// Shared constants and types for the chained Zorro II autoconfig engine.
package autoconfig_pkg;

    localparam logic [5:0] ER_TYPE    = 6'h00;
    localparam logic [5:0] ER_PROD    = 6'h02;
    localparam logic [5:0] ER_FLAGS   = 6'h04;
    localparam logic [5:0] ER_MFG     = 6'h08;
    localparam logic [5:0] ER_SERIAL  = 6'h0C;
    localparam logic [5:0] EC_BASE_HI = 6'h24;
    localparam logic [5:0] EC_BASE_LO = 6'h25;
    localparam logic [5:0] EC_SHUTUP  = 6'h26;

    localparam logic [7:0] AUTOCONFIG_SPACE = 8'hE8;

    typedef enum logic {CFG, DONE} state_e;

    // Mask over A[23:16] that selects the bits above a window of 2**size_log2 bytes.
    function automatic logic [7:0] size_mask(input logic [4:0] size_log2);
        return 8'hFF << (size_log2 - 5'd16);
    endfunction

endpackage

// File: rtl/autoconfig_zn_if.sv
// Bus-side signal bundle of the autoconfig engine (68020 strobes, address, data, selects).
interface autoconfig_zn_if #(
    parameter int unsigned NUM_CARDS = 2
);
    logic                 AS20;
    logic                 DS20;
    logic                 RW20;
    logic [23:0]          A;
    logic [15:0]          D;
    logic [3:0]           DOUT;
    logic                 ACCESS;
    logic                 ACK;
    logic [NUM_CARDS-1:0] DECODE;

    modport master (output AS20, DS20, RW20, A, D, input DOUT, ACCESS, ACK, DECODE);
    modport slave  (input AS20, DS20, RW20, A, D, output DOUT, ACCESS, ACK, DECODE);
endinterface

// File: rtl/autoconfig_rom.sv
// Nibble lookup of one card's autoconfig ROM; serial nibbles only with AUTOCONFIG_SERIAL_EN.
module autoconfig_rom
    import autoconfig_pkg::*;
(
    input  logic [7:0]  er_type,
    input  logic [7:0]  er_prod,
    input  logic [7:0]  er_flags,
    input  logic [15:0] mfg_id,
    input  logic [31:0] serial,
    input  logic [5:0]  zaddr,
    output logic [3:0]  nibble_c
);
    // Only er_Type is stored true; every other register reads back inverted.
    always_comb begin
        nibble_c = 4'hF;
        case (zaddr)
            ER_TYPE:              nibble_c = er_type[7:4];
            ER_TYPE + 6'd1:       nibble_c = er_type[3:0];
            ER_PROD:              nibble_c = ~er_prod[7:4];
            ER_PROD + 6'd1:       nibble_c = ~er_prod[3:0];
            ER_FLAGS:             nibble_c = ~er_flags[7:4];
            ER_FLAGS + 6'd1:      nibble_c = ~er_flags[3:0];
            ER_MFG:               nibble_c = ~mfg_id[15:12];
            ER_MFG + 6'd1:        nibble_c = ~mfg_id[11:8];
            ER_MFG + 6'd2:        nibble_c = ~mfg_id[7:4];
            ER_MFG + 6'd3:        nibble_c = ~mfg_id[3:0];
`ifdef AUTOCONFIG_SERIAL_EN
            ER_SERIAL:            nibble_c = ~serial[31:28];
            ER_SERIAL + 6'd1:     nibble_c = ~serial[27:24];
            ER_SERIAL + 6'd2:     nibble_c = ~serial[23:20];
            ER_SERIAL + 6'd3:     nibble_c = ~serial[19:16];
            ER_SERIAL + 6'd4:     nibble_c = ~serial[15:12];
            ER_SERIAL + 6'd5:     nibble_c = ~serial[11:8];
            ER_SERIAL + 6'd6:     nibble_c = ~serial[7:4];
            ER_SERIAL + 6'd7:     nibble_c = ~serial[3:0];
`endif
            default:              nibble_c = 4'hF;
        endcase
    end

`ifdef AUTOCONFIG_SERIAL_EN
`else
    logic unused_serial;
    assign unused_serial = ^serial;
`endif

endmodule

// File: rtl/autoconfig_zn.sv
// CLKCPU-synchronous autoconfig engine for NUM_CARDS boards behind one slot at $E80000.
// Optional serial-number ROM registers are enabled by AUTOCONFIG_SERIAL_EN.
module autoconfig_zn
    import autoconfig_pkg::*;
#(
    parameter int unsigned                  NUM_CARDS      = 2,
    parameter logic [15:0]                  MFG_ID         = 16'h0A1C,
    parameter logic [31:0]                  SERIAL         = 32'h00000000,
    parameter logic [8*NUM_CARDS-1:0]       CARD_TYPE      = {8'hC1, 8'hE6},
    parameter logic [8*NUM_CARDS-1:0]       CARD_PROD      = {8'h7F, 8'h7F},
    parameter logic [8*NUM_CARDS-1:0]       CARD_FLAGS     = {8'h00, 8'h00},
    parameter logic [5*NUM_CARDS-1:0]       CARD_SIZE_LOG2 = {5'd16, 5'd21}
) (
    input  logic           CLKCPU,
    input  logic           RESET,
    autoconfig_zn_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [3:0]                 base_lo_q, base_lo_d;
    logic [NUM_CARDS-1:0][7:0]  base_q, base_d;
    logic [NUM_CARDS-1:0]       cfg_q, cfg_d;
    logic [NUM_CARDS-1:0]       shut_q, shut_d;
    logic [3:0]                 dout_q, dout_d;
    logic                       ack_q, ack_d;
    logic                       ack_pend_q, ack_pend_d;
    logic                       as_s1_q, as_s2_q, ds_s1_q, ds_s2_q, ds_prev_q;

    logic                       hit_c, ds_fall_c, complete_c;
    logic [5:0]                 zaddr_c;
    logic [3:0]                 rom_c;
    logic [NUM_CARDS-1:0]       decode_c;

    assign zaddr_c   = bus.A[6:1];
    assign hit_c     = (bus.A[23:16] == AUTOCONFIG_SPACE) && (state_q != DONE);
    assign ds_fall_c = ds_prev_q && !ds_s2_q && !as_s2_q;

    autoconfig_rom u_rom (
        .er_type  (CARD_TYPE[{idx_q, 3'b000} +: 8]),
        .er_prod  (CARD_PROD[{idx_q, 3'b000} +: 8]),
        .er_flags (CARD_FLAGS[{idx_q, 3'b000} +: 8]),
        .mfg_id   (MFG_ID),
        .serial   (SERIAL),
        .zaddr    (zaddr_c),
        .nibble_c (rom_c)
    );

    // Bus cycle decode, card sequencing and acknowledge generation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_lo_d  = base_lo_q;
        base_d     = base_q;
        cfg_d      = cfg_q;
        shut_d     = shut_q;
        dout_d     = dout_q;
        ack_d      = ack_q;
        ack_pend_d = ack_pend_q;
        complete_c = 1'b0;

        if (ds_fall_c && hit_c) begin
            ack_pend_d = 1'b1;
            if (bus.RW20) begin
                dout_d = rom_c;
            end else begin
                case (zaddr_c)
                    EC_BASE_LO: base_lo_d = bus.D[15:12];
                    EC_BASE_HI: begin
                        base_d[idx_q] = {bus.D[15:12], base_lo_q};
                        cfg_d[idx_q]  = 1'b1;
                        complete_c    = 1'b1;
                    end
                    EC_SHUTUP: begin
                        shut_d[idx_q] = 1'b1;
                        complete_c    = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (complete_c) begin
                if (idx_q == IDX_W'(NUM_CARDS - 1)) state_d = DONE;
                else                                idx_d   = idx_q + IDX_W'(1);
            end
        end

        if (ack_pend_q) ack_d = 1'b0;
        if (as_s2_q) begin
            ack_pend_d = 1'b0;
            ack_d      = 1'b1;
        end
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q    <= CFG;
            idx_q      <= '0;
            base_lo_q  <= '0;
            base_q     <= '0;
            cfg_q      <= '0;
            shut_q     <= '0;
            dout_q     <= 4'hF;
            ack_q      <= 1'b1;
            ack_pend_q <= 1'b0;
            as_s1_q    <= 1'b1;
            as_s2_q    <= 1'b1;
            ds_s1_q    <= 1'b1;
            ds_s2_q    <= 1'b1;
            ds_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_lo_q  <= base_lo_d;
            base_q     <= base_d;
            cfg_q      <= cfg_d;
            shut_q     <= shut_d;
            dout_q     <= dout_d;
            ack_q      <= ack_d;
            ack_pend_q <= ack_pend_d;
            as_s1_q    <= bus.AS20;
            as_s2_q    <= as_s1_q;
            ds_s1_q    <= bus.DS20;
            ds_s2_q    <= ds_s1_q;
            ds_prev_q  <= ds_s2_q;
        end
    end

    // Window select compares only the address bits above each card's size.
    always_comb begin
        decode_c = '1;
        for (int i = 0; i < int'(NUM_CARDS); i++) begin
            if (cfg_q[i] && !shut_q[i] &&
                ((bus.A[23:16] & size_mask(CARD_SIZE_LOG2[i*5 +: 5])) ==
                 (base_q[i]    & size_mask(CARD_SIZE_LOG2[i*5 +: 5]))))
                decode_c[i] = 1'b0;
        end
    end

    assign bus.DOUT   = dout_q;
    assign bus.ACK    = ack_q;
    assign bus.ACCESS = ~hit_c;
    assign bus.DECODE = decode_c;

    logic unused_bus;
    assign unused_bus = ^{bus.A[15:7], bus.A[0], bus.D[11:0]};

endmodule

// File: doc/autoconfig_zn.md
Name: autoconfig_zn

Overview:
- Parametrised Zorro II autoconfig engine for NUM_CARDS logical boards chained behind one physical slot at $E80000.
- Serves each card's nibble-wide autoconfig ROM in turn and accepts the OS-assigned base address (no hardcoded bases).
- Produces per-card active-low decode strobes from the assigned base and size.
- Replaces the single-rate, DS-clocked two-card engine with a CLKCPU-synchronous design that also generates its own acknowledge.

Parameters:
- NUM_CARDS, 2, number of chained logical boards (1..4).
- MFG_ID, 16'h0A1C, manufacturer number shared by all cards.
- SERIAL, 32'h00000000, serial number shared by all cards.
- CARD_TYPE, {8'hC1,8'hE6}, er_Type byte per card, card0 in LSBs, 8 bits per card.
- CARD_PROD, {8'h7F,8'h7F}, er_Product byte per card, 8 bits per card.
- CARD_FLAGS, {8'h00,8'h00}, er_Flags byte per card, 8 bits per card.
- CARD_SIZE_LOG2, {5'd16,5'd21}, log2 of window bytes per card (16..23), 5 bits per card.

Ports:
- CLKCPU  in  1  system clock.
- RESET  in  1  asynchronous active-low reset.
- AS20  in  1  address strobe, active low, async to CLKCPU.
- DS20  in  1  data strobe, active low, async to CLKCPU.
- RW20  in  1  1=read, 0=write.
- A  in  24  byte address; [6:1] select the ROM register, [23:16] select the space.
- D  in  16  write data; D[15:12] carry the base nibble.
- DOUT  out  4  read nibble, driven onto D[15:12] by the top level.
- ACCESS  out  1  active low; autoconfig space hit while unconfigured cards remain.
- ACK  out  1  active low; cycle acknowledge to the bus glue.
- DECODE  out  NUM_CARDS  active low per-card window select.

Behaviour:
- AS20/DS20 pass through 2-flop synchronisers. ds_fall = synchronised DS20 1->0 while synchronised AS20 = 0; each ds_fall is processed exactly once.
- hit = (A[23:16]==8'hE8) & (state != DONE). ACCESS = ~hit, combinational from A and state.
- State machine:
  - CFG(idx): idx counter 0..NUM_CARDS-1. Reset goes to CFG(0).
  - On a completing write, if idx == NUM_CARDS-1 go to DONE; otherwise idx+1.
  - DONE: sticky until reset; no further reads or writes are decoded.
- Reads (hit & RW20=1 on ds_fall) register DOUT one clock later. zaddr = A[6:1]:
  - 00/01: type hi/lo nibble, true polarity.
  - 02/03: product nibbles, inverted.
  - 04/05: flags nibbles, inverted.
  - 08..0B: MFG_ID nibbles, MSB first, inverted.
  - 0C..13: SERIAL nibbles, MSB first, inverted.
  - All other offsets: 4'hF.
- Writes (hit & RW20=0 on ds_fall):
  - zaddr 25 ($4A): latch D[15:12] into base_lo.
  - zaddr 24 ($48): base[idx] <= {D[15:12], base_lo}; configured[idx] <= 1; complete the card.
  - zaddr 26 ($4C): shutup[idx] <= 1; complete the card.
  - All other offsets are ignored.
- ACK goes low 2 clocks after ds_fall for hit cycles, and stays low until synchronised AS20 = 1. ACK is never asserted for non-hit cycles.
- DECODE[i] = 0 iff configured[i] & ~shutup[i] & A[23:CARD_SIZE_LOG2[i]] == base[i][23:CARD_SIZE_LOG2[i]] (base stored as A[23:16]). DECODE is combinational.
- Reset values:
  - DOUT = 4'hF, ACK = 1, DECODE = all 1s.
  - configured = 0, shutup = 0, base = 0, base_lo = 0, idx = 0.
- Boundaries:
  - AS20 negated before DS20 falls: no action.
  - Reset mid-cycle returns everything to reset values immediately.
  - A write to $48 after $4C on the same card is impossible because idx has already advanced.
  - A $48 write without a prior $4A write uses base_lo = 0.

Optional Feature:
- AUTOCONFIG_SERIAL_EN.
- Defined: offsets 0C..13 return inverted SERIAL nibbles.
- Undefined: those offsets return 4'hF and the SERIAL parameter is unused.

Decomposition:
- Package autoconfig_pkg holds:
  - zaddr offset constants (ER_TYPE, ER_PROD, ER_FLAGS, ER_MFG, ER_SERIAL, EC_BASE_HI=6'h24, EC_BASE_LO=6'h25, EC_SHUTUP=6'h26).
  - AUTOCONFIG_SPACE = 8'hE8.
  - State enum {CFG, DONE}.
- One natural sub-module: autoconfig_rom, a combinational nibble lookup from (card params, zaddr) to DOUT value.

Test Plan:
- Reset, read zaddr 00 and 01 for card0 with defaults -> DOUT = 4'hE then 4'h6, each 1 clk after ds_fall; ACK low 2 clks after ds_fall, high after AS20 rises.
- Read zaddr 08 -> 4'hF (~0x0); read zaddr 30 -> 4'hF.
- Write $4A D=0x0000, then $48 D=0x2000 -> base[0]=8'h20; A=24'h200000..3FFFFF gives DECODE[0]=0; card1 ROM is now visible (zaddr 00 reads 4'hC).
- Write $4C to card1 -> state DONE; A=24'hE80000 gives ACCESS=1, ACK stays 1; DECODE[1] stays 1 for any address.
- Assert RESET between ds_fall and ACK on a $48 write -> configured=0, DECODE all 1s, ACK=1, DOUT=4'hF, idx=0.
- With AUTOCONFIG_SERIAL_EN and SERIAL=32'h12345678, read zaddr 0C -> 4'hE; without the macro -> 4'hF.
